// File: rtl/bcd_menu_pkg.sv
// rtl/bcd_menu_pkg.sv - shared widths and FSM state type for the BCD convert scheduler
package bcd_menu_pkg;

    localparam int BIN_W      = 17;
    localparam int BCD_W      = 20;
    localparam int DIGITS     = 5;
    localparam int CONV_STEPS = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_convert_scheduler_dd_step.sv
// rtl/bcd_convert_scheduler_dd_step.sv - one combinational double-dabble step
module dd_step
    import bcd_menu_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic [BIN_W-1:0] bin_out
);

    logic [BCD_W-1:0] adj;

    // Add 3 to every digit that would overflow past 9 once doubled by the shift
    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
            end else begin
                adj[4*d +: 4] = bcd_in[4*d +: 4];
            end
        end
    end

    // The binary MSB shifts into the units digit of the BCD accumulator
    assign bcd_out = {adj[BCD_W-2:0], bin_in[BIN_W-1]};
    assign bin_out = {bin_in[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin shared binary-to-BCD converter for menu fields
module bcd_convert_scheduler
    import bcd_menu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MAX_VAL = 99999
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [BIN_W*N_REQ-1:0] req_value,
    output logic                   busy,
    output logic [N_REQ-1:0]       pending,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [BCD_W-1:0]       res_bcd,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_ovf
);

    localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);
    localparam logic [4:0]       LAST_STEP = 5'(CONV_STEPS - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    N_WIDE    = (ID_W+1)'(N_REQ);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   hold_val [N_REQ];
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    job_id;
    logic [ID_W:0]      scan_sum;
    logic               grant_found;
    logic               grant;
    logic [BIN_W-1:0]   sel_val;
    logic [BIN_W-1:0]   bin_reg;
    logic [BIN_W-1:0]   step_bin;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   step_bcd;
    logic [4:0]         step_cnt;
    logic               job_ovf;

    dd_step u_dd_step (
        .bcd_in  (bcd_reg),
        .bin_in  (bin_reg),
        .bcd_out (step_bcd),
        .bin_out (step_bin)
    );

    // Round-robin search: scan from rr_ptr upward with wrap; the nearest pending channel wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= N_WIDE) begin
                scan_sum = scan_sum - N_WIDE;
            end
            if (pending[scan_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[ID_W-1:0];
            end
        end
    end

    assign grant   = (state == IDLE) && en && grant_found;
    assign sel_val = hold_val[grant_idx];
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant starts a job, the last step presents it, the handshake retires it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SHIFT;
            SHIFT:   if (step_cnt == LAST_STEP) state_nxt = OUT;
            OUT:     if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; a fresh req beats the grant clear so a same-edge repost stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                hold_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    pending[i]  <= 1'b1;
                    hold_val[i] <= req_value[BIN_W*i +: BIN_W];
                end else if (grant && (grant_idx == ID_W'(i))) begin
                    pending[i]  <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the channel that was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        end
    end

    // Conversion datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg   <= '0;
            bin_reg   <= '0;
            step_cnt  <= '0;
            job_id    <= '0;
            job_ovf   <= 1'b0;
            res_valid <= 1'b0;
            res_bcd   <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
        end else if (grant) begin
            bcd_reg  <= '0;
            bin_reg  <= (sel_val > MAX_BIN) ? MAX_BIN : sel_val;
            job_ovf  <= (sel_val > MAX_BIN);
            job_id   <= grant_idx;
            step_cnt <= '0;
        end else if (state == SHIFT) begin
            bcd_reg  <= step_bcd;
            bin_reg  <= step_bin;
            step_cnt <= step_cnt + 5'd1;
            if (step_cnt == LAST_STEP) begin
                res_valid <= 1'b1;
                res_bcd   <= step_bcd;
                res_id    <= job_id;
                res_ovf   <= job_ovf;
            end
        end else if ((state == OUT) && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - scoreboard bench for the BCD convert scheduler
module tb_bcd_convert_scheduler;

    typedef struct {
        logic [1:0]  id;
        logic [19:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [67:0] req_value = '0;
    logic        busy;
    logic [3:0]  pending;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [19:0] res_bcd;
    logic [1:0]  res_id;
    logic        res_ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];
    exp_t mon_e;

    bcd_convert_scheduler #(.N_REQ(4), .ID_W(2), .MAX_VAL(99999)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .req_value (req_value),
        .busy      (busy),
        .pending   (pending),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_bcd   (res_bcd),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic push_exp(input int ch, input int val);
        exp_t e;
        e.id  = 2'(ch);
        e.ovf = (val > 99999);
        e.bcd = to_bcd((val > 99999) ? 99999 : val);
        sb.push_back(e);
    endtask

    task automatic pulse(input int ch, input int val);
        @(posedge clk); #1;
        req[ch] = 1'b1;
        req_value[17*ch +: 17] = 17'(val);
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic pulse2(input int ch_a, input int val_a, input int ch_b, input int val_b);
        @(posedge clk); #1;
        req[ch_a] = 1'b1;
        req[ch_b] = 1'b1;
        req_value[17*ch_a +: 17] = 17'(val_a);
        req_value[17*ch_b +: 17] = 17'(val_b);
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done;
        done = 0;
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk); #1;
            if (!busy && !res_valid && pending == 4'b0 && sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL wait_idle: timeout, busy=%0b pending=%b queued=%0d, required idle with empty queue",
                     busy, pending, sb.size());
        end
    endtask

    // Scoreboard: every accepted result must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got id=%0d bcd=%h ovf=%0b, required no result",
                         res_id, res_bcd, res_ovf);
            end else begin
                mon_e = sb.pop_front();
                n_cmp++;
                if (res_id !== mon_e.id) begin
                    n_bad++;
                    $display("FAIL res_id: got %0d, required %0d", res_id, mon_e.id);
                end
                n_cmp++;
                if (res_bcd !== mon_e.bcd) begin
                    n_bad++;
                    $display("FAIL res_bcd: got %h, required %h (id %0d)", res_bcd, mon_e.bcd, mon_e.id);
                end
                n_cmp++;
                if (res_ovf !== mon_e.ovf) begin
                    n_bad++;
                    $display("FAIL res_ovf: got %0b, required %0b (id %0d)", res_ovf, mon_e.ovf, mon_e.id);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, res_valid, res_ovf} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy/valid/ovf=%b, required 000", {busy, res_valid, res_ovf});
        end
        n_cmp++;
        if (pending !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_pending: got %b, required 0000", pending);
        end
        n_cmp++;
        if (res_bcd !== 20'h0 || res_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_result: got bcd=%h id=%0d, required 00000 / 0", res_bcd, res_id);
        end
        rst_n = 1'b1;
        en = 1'b1;
        res_ready = 1'b1;
    endtask

    task automatic test_latency();
        push_exp(1, 12345);
        pulse(1, 12345);
        n_cmp++;
        if (pending[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_pending: got %b, required bit1 set", pending);
        end
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                n_cmp++;
                if (busy !== 1'b1 || pending[1] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_grant: got busy=%0b pending=%b, required busy=1 pending[1]=0", busy, pending);
                end
            end
            if (n == 17) begin
                n_cmp++;
                if (res_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_early: got res_valid=%0b at edge 17, required 0", res_valid);
                end
            end
            if (n == 18) begin
                n_cmp++;
                if (res_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL latency_valid: got res_valid=%0b at edge 18, required 1", res_valid);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL one_cycle_valid: got res_valid=%0b after handshake, required 0", res_valid);
        end
        wait_idle(60);
    endtask

    task automatic test_values();
        push_exp(0, 0);
        push_exp(3, 99999);
        pulse(0, 0);
        pulse(3, 99999);
        wait_idle(100);
    endtask

    task automatic test_round_robin();
        // pointer is 0 here: ch0 before ch2
        push_exp(0, 7);
        push_exp(2, 42);
        pulse2(0, 7, 2, 42);
        wait_idle(100);
        // a lone ch0 job leaves the pointer at 1
        push_exp(0, 1);
        pulse(0, 1);
        wait_idle(60);
        // pointer is 1 here: ch2 before ch0
        push_exp(2, 42);
        push_exp(0, 7);
        pulse2(0, 7, 2, 42);
        wait_idle(100);
    endtask

    task automatic test_saturation();
        push_exp(2, 100000);
        pulse(2, 100000);
        wait_idle(60);
        push_exp(2, 131071);
        pulse(2, 131071);
        wait_idle(60);
    endtask

    task automatic test_backpressure();
        bit got;
        res_ready = 1'b0;
        push_exp(3, 321);
        pulse(3, 321);
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                got = 1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL bp_valid: got no res_valid within 40 cycles, required valid");
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || res_bcd !== to_bcd(321) ||
                res_id !== 2'd3 || res_ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold: cycle %0d got valid=%0b busy=%0b bcd=%h id=%0d ovf=%0b, required 1 1 00321 3 0",
                         c, res_valid, busy, res_bcd, res_id, res_ovf);
            end
            if (c == 4) begin
                push_exp(1, 555);
                req[1] = 1'b1;
                req_value[17 +: 17] = 17'd555;
            end
            if (c == 5) begin
                req = '0;
            end
        end
        n_cmp++;
        if (pending !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_pending: got %b, required 0010", pending);
        end
        res_ready = 1'b1;
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        bit seen;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b1;
        req[1] = 1'b1;
        req_value[0 +: 17]  = 17'd1111;
        req_value[17 +: 17] = 17'd2222;
        @(posedge clk); #1;
        req = '0;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_busy: got busy=%0b before reset, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pending !== 4'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_flags: got pending=%b busy=%0b valid=%0b, required 0000 0 0", pending, busy, res_valid);
        end
        n_cmp++;
        if (res_bcd !== 20'h0 || res_id !== 2'd0 || res_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_result: got bcd=%h id=%0d ovf=%0b, required 00000 0 0", res_bcd, res_id, res_ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (res_valid || busy || pending != 4'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL rm_no_result: activity seen after reset release, required none");
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_round_robin();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d results outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_convert_scheduler.md
Name: bcd_convert_scheduler

Overview:
- Shares one sequential binary-to-BCD converter (5 digits, 0..99999) between N_REQ menu-field requesters.
- Requesters post a 17-bit value with a one-cycle request pulse. The block arbitrates round-robin, runs an iterative double-dabble conversion, and presents the packed BCD result to the display writer on a valid/ready handshake.
- It sits between the menu value sources and the character-ROM address logic.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of channel id; must satisfy 2**ID_W >= N_REQ
MAX_VAL, 99999, saturation limit for input values

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low blocks new grants but does not stop a conversion in progress
req  in  N_REQ  per-channel conversion request pulse
req_value  in  17*N_REQ  per-channel binary value; channel i occupies bits [17*i+16:17*i]
busy  out  1  conversion in progress or result waiting
pending  out  N_REQ  per-channel request-outstanding flags
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_bcd  out  20  packed BCD: [3:0] units .. [19:16] tens of thousands
res_id  out  ID_W  channel that owns res_bcd
res_ovf  out  1  input exceeded MAX_VAL and was clamped

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pending=0; rr pointer=0; res_valid=0, res_bcd=0, res_id=0, res_ovf=0; busy=0.
  - Reset mid-conversion discards all work.
- Request capture:
  - On a clock edge where req[i]=1, pending[i] is set and req_value slice i is latched into a per-channel holding register.
  - A new req on a channel that is already pending overwrites the held value; requests coalesce, last value wins.
  - A req on the channel currently being converted sets pending again. That channel is reconverted later with the new value.
- State machine: IDLE -> SHIFT -> OUT -> IDLE.
- IDLE:
  - If en=1 and pending!=0, grant the first set pending bit, searching from the rr pointer upward with wrap.
  - On that edge: clear the granted pending bit (unless req for it is asserted on the same edge), load its held value, set rr pointer to grant+1 mod N_REQ, go to SHIFT with shift count=0.
  - If the value > MAX_VAL, load MAX_VAL and set the ovf flag for this job.
- SHIFT:
  - Exactly 17 cycles, one double-dabble step per cycle: any BCD nibble >=5 gets +3, then shift left 1 with the next binary MSB.
  - After the 17th step, go to OUT and drive res_valid=1 with res_bcd, res_id and res_ovf.
- OUT:
  - res_bcd, res_id and res_ovf are held stable while res_valid=1 and res_ready=0.
  - On an edge with res_valid&res_ready: res_valid goes to 0 and the state returns to IDLE. The next grant can occur on the following edge.
- Latency: req sampled at edge k with the block idle and en=1 -> grant at k+1 -> res_valid high after edge k+18.
- Throughput: one result per 19 cycles when res_ready is tied high.
- busy=1 in SHIFT and OUT.
- en is sampled only in IDLE.
- Digits are always 0..9. Values above MAX_VAL never produce a non-decimal nibble.

Decomposition:
- Package bcd_menu_pkg holds:
  - BIN_W=17, BCD_W=20, DIGITS=5, CONV_STEPS=17.
  - The state enum {IDLE, SHIFT, OUT}.
- Sub-module dd_step: combinational single double-dabble step. It takes {bcd[19:0], bin[16:0]} and returns the adjusted and shifted pair. The scheduler instantiates it once and iterates it.
- Arbiter logic stays inline in bcd_convert_scheduler.

Test Plan:
- Ch1 req with value 12345, res_ready=1 -> res_valid 18 edges later; res_bcd=20'h12345, res_id=1, res_ovf=0; one-cycle valid.
- Ch0 value 0, then ch3 value 99999 -> res_bcd=20'h00000 then 20'h99999; ch3 result has res_ovf=0.
- Ch2 value 100000 (17'h186A0) and ch2 value 131071 -> both give res_bcd=20'h99999 with res_ovf=1.
- Same-edge req on ch0 and ch2 (values 7 and 42), rr pointer=0 -> results in order id0=20'h00007, then id2=20'h00042. Repeat with pointer=1 -> ch2 is served first.
- Backpressure: hold res_ready=0 for 30 cycles after res_valid -> outputs stable, no new grant. A ch1 req during the hold is kept in pending[1] and served after the handshake.
- Reset: assert rst_n=0 at SHIFT step 8 with ch0 and ch1 pending -> all outputs and pending return to 0 immediately. No result appears after rst_n is released.
